// File: rtl/writeback_stage.sv
// Writeback buffer: queues completed ALU and load results and drains them in
// order onto the single register-file write port. Also reports pending
// destination registers to decode and signals when the buffer is empty.
module writeback_stage #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_value,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_value,
    output logic        mem_ready,
    output logic        write_enable,
    output logic [4:0]  write_register,
    output logic [63:0] write_value,
    input  logic        write_ready,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        busy1,
    output logic        busy2,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [4:0]    entry_rd_q  [DEPTH];
    logic [4:0]    entry_rd_d  [DEPTH];
    logic [63:0]   entry_val_q [DEPTH];
    logic [63:0]   entry_val_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          not_full;
    logic          mem_fire;
    logic          alu_fire;
    logic [4:0]    push_rd;
    logic [63:0]   push_value;
    logic          store;
    logic          pop;
    logic [AW-1:0] offset;

    // Handshake, arbitration (load path wins) and next-state for pointers/count.
    // Ready depends only on the pre-edge count, so a same-cycle pop never frees a slot.
    always_comb begin
        not_full   = (count_q < FULL_COUNT);
        mem_ready  = not_full;
        alu_ready  = not_full && !mem_valid;
        mem_fire   = mem_valid && mem_ready;
        alu_fire   = alu_valid && alu_ready;
        push_rd    = mem_fire ? mem_rd : alu_rd;
        push_value = mem_fire ? mem_value : alu_value;
        // Writes to x0 complete the handshake but are dropped here.
        store      = (mem_fire || alu_fire) && (push_rd != 5'd0);
        pop        = (count_q != '0) && write_ready;

        entry_rd_d  = entry_rd_q;
        entry_val_d = entry_val_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (store) begin
            entry_rd_d[wr_ptr_q]  = push_rd;
            entry_val_d[wr_ptr_q] = push_value;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW + 1)'(store) - (AW + 1)'(pop);
    end

    // Head presentation to the register file; zeroed while empty.
    always_comb begin
        empty          = (count_q == '0);
        write_enable   = !empty;
        write_register = '0;
        write_value    = '0;
        if (write_enable) begin
            write_register = entry_rd_q[rd_ptr_q];
            write_value    = entry_val_q[rd_ptr_q];
        end
    end

    // Scoreboard lookup over occupied entries only (distance from head < count).
    always_comb begin
        busy1  = 1'b0;
        busy2  = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) begin
                if ((query_rs1 != 5'd0) && (entry_rd_q[i] == query_rs1)) busy1 = 1'b1;
                if ((query_rs2 != 5'd0) && (entry_rd_q[i] == query_rs2)) busy2 = 1'b1;
            end
        end
    end

    // Control state: pointers and occupancy, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed when counted as occupied, so no reset.
    always_ff @(posedge clk) begin
        entry_rd_q  <= entry_rd_d;
        entry_val_q <= entry_val_d;
    end

endmodule
